// File: rtl/vsync_gen.sv
// Vertical timing generator: counts lines on end-of-line strobes and decodes
// blank/sync/draw-done, plus cell row/line tracking and frame strobes for the maze renderer.
module vsync_gen #(
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int CNT_W    = 10
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             i_LineEnd,
   input  logic [5:0]       i_PixelSize,
   output logic             vblank,
   output logic             vsync_out,
   output logic [CNT_W-1:0] vPos,
   output logic             vDrawDone,
   output logic [9:0]       o_CellRow,
   output logic [5:0]       o_CellLine,
   output logic             o_FrameStart,
   output logic [7:0]       o_FrameCnt
);

   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [31:0] ACT_END  = 32'(V_ACTIVE);
   localparam logic [31:0] SYNC_BEG = 32'(V_ACTIVE + V_FP);
   localparam logic [31:0] SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [31:0] LAST     = 32'(V_TOTAL - 1);

   logic [CNT_W-1:0] vcnt_q, vcnt_d;
   logic [5:0]       sz_q, sz_d;
   logic [9:0]       cell_row_q, cell_row_d;
   logic [5:0]       cell_line_q, cell_line_d;
   logic             frame_start_q, frame_start_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;

   // Decoding is done at 32 bits so the sync end bound cannot alias when V_TOTAL == 2^CNT_W.
   logic [31:0] vcnt_w, vnext_w;
   assign vcnt_w  = 32'(vcnt_q);
   assign vnext_w = vcnt_w + 32'd1;

   always_comb begin
      vcnt_d        = vcnt_q;
      sz_d          = sz_q;
      cell_row_d    = cell_row_q;
      cell_line_d   = cell_line_q;
      frame_start_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      if (i_LineEnd) begin
         if (vcnt_w == LAST) begin
            vcnt_d        = '0;
            sz_d          = (i_PixelSize == 6'd0) ? 6'd1 : i_PixelSize;
            cell_row_d    = '0;
            cell_line_d   = '0;
            frame_start_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 8'd1;
         end else begin
            vcnt_d = CNT_W'(vnext_w);
            // Cell outputs freeze through blanking so the last visible cell stays addressed.
            if (vnext_w < ACT_END) begin
               if (cell_line_q == sz_q - 6'd1) begin
                  cell_line_d = '0;
                  cell_row_d  = cell_row_q + 10'd1;
               end else begin
                  cell_line_d = cell_line_q + 6'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         vcnt_q        <= '0;
         sz_q          <= 6'd1;
         cell_row_q    <= '0;
         cell_line_q   <= '0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         vcnt_q        <= vcnt_d;
         sz_q          <= sz_d;
         cell_row_q    <= cell_row_d;
         cell_line_q   <= cell_line_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign vPos         = vcnt_q;
   assign vblank       = (vcnt_w >= ACT_END);
   assign vDrawDone    = (vcnt_w == ACT_END - 32'd1);
   assign vsync_out    = ((vcnt_w >= SYNC_BEG) && (vcnt_w < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
   assign o_CellRow    = cell_row_q;
   assign o_CellLine   = cell_line_q;
   assign o_FrameStart = frame_start_q;
   assign o_FrameCnt   = frame_cnt_q;

endmodule

// File: tb/tb_vsync_gen.sv
// Directed bench for vsync_gen: default, overridden and tiny geometries.
module tb_vsync_gen;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Default geometry instance
   logic       le0 = 1'b0;
   logic [5:0] ps0 = 6'd1;
   logic       vb0, vs0, dd0, fs0;
   logic [9:0] pos0, row0;
   logic [5:0] line0;
   logic [7:0] fc0;

   vsync_gen u0 (
      .Clk(Clk), .Rst(Rst), .i_LineEnd(le0), .i_PixelSize(ps0),
      .vblank(vb0), .vsync_out(vs0), .vPos(pos0), .vDrawDone(dd0),
      .o_CellRow(row0), .o_CellLine(line0), .o_FrameStart(fs0), .o_FrameCnt(fc0)
   );

   // Overridden geometry, active-high sync
   logic       le1 = 1'b0;
   logic [5:0] ps1 = 6'd1;
   logic       vb1, vs1, dd1, fs1;
   logic [9:0] pos1, row1;
   logic [5:0] line1;
   logic [7:0] fc1;

   vsync_gen #(.V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23), .SYNC_POL(1'b1), .CNT_W(10)) u1 (
      .Clk(Clk), .Rst(Rst), .i_LineEnd(le1), .i_PixelSize(ps1),
      .vblank(vb1), .vsync_out(vs1), .vPos(pos1), .vDrawDone(dd1),
      .o_CellRow(row1), .o_CellLine(line1), .o_FrameStart(fs1), .o_FrameCnt(fc1)
   );

   // Tiny 7-line geometry so 256 frames fit in a short run
   logic       le2 = 1'b0;
   logic [5:0] ps2 = 6'd1;
   logic       vb2, vs2, dd2, fs2;
   logic [2:0] pos2;
   logic [9:0] row2;
   logic [5:0] line2;
   logic [7:0] fc2;

   vsync_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0), .CNT_W(3)) u2 (
      .Clk(Clk), .Rst(Rst), .i_LineEnd(le2), .i_PixelSize(ps2),
      .vblank(vb2), .vsync_out(vs2), .vPos(pos2), .vDrawDone(dd2),
      .o_CellRow(row2), .o_CellLine(line2), .o_FrameStart(fs2), .o_FrameCnt(fc2)
   );

   typedef struct {
      int         n;
      logic [5:0] ps;
      int         pos;
      bit         vb;
      bit         vs;
      bit         dd;
      int         row;
      int         line;
      bit         fs;
      int         fcnt;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_reset0(input string tag);
      chk({tag, "_vpos"},  32'(pos0),  32'd0);
      chk({tag, "_vblank"}, 32'(vb0),  32'd0);
      chk({tag, "_vsync"}, 32'(vs0),   32'd1);
      chk({tag, "_ddone"}, 32'(dd0),   32'd0);
      chk({tag, "_row"},   32'(row0),  32'd0);
      chk({tag, "_line"},  32'(line0), 32'd0);
      chk({tag, "_fs"},    32'(fs0),   32'd0);
      chk({tag, "_fcnt"},  32'(fc0),   32'd0);
   endtask

   task automatic run0(input int n);
      @(negedge Clk);
      le0 = 1'b1;
      repeat (n) @(negedge Clk);
      le0 = 1'b0;
   endtask

   task automatic pulse0();
      @(negedge Clk);
      le0 = 1'b1;
      @(negedge Clk);
      le0 = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_pos;
      int pulses;
      // Power-on reset, checked before any clock edge
      #1 Rst = 1'b0;
      #2;
      chk_reset0("por");
      chk("por_u1_vsync", 32'(vs1), 32'd0);
      @(negedge Clk);
      Rst = 1'b1;

      // One default frame of single-cycle strobes; new size 8 only takes effect after the wrap
      ps0 = 6'd8;
      for (int i = 1; i <= 525; i++) begin
         pulse0();
         exp_pos = i % 525;
         chk($sformatf("scan_vpos@%0d", i),  32'(pos0), 32'(exp_pos));
         chk($sformatf("scan_vblank@%0d", i), 32'(vb0), 32'(exp_pos >= 480));
         chk($sformatf("scan_vsync@%0d", i), 32'(vs0), 32'(!(exp_pos == 490 || exp_pos == 491)));
         chk($sformatf("scan_ddone@%0d", i), 32'(dd0), 32'(exp_pos == 479));
         chk($sformatf("scan_row@%0d", i),   32'(row0), 32'((exp_pos < 480) ? exp_pos : 479));
         chk($sformatf("scan_fs@%0d", i),    32'(fs0), 32'(i == 525));
         chk($sformatf("scan_fcnt@%0d", i),  32'(fc0), 32'((i == 525) ? 1 : 0));
      end
      @(negedge Clk);
      chk("fs_one_cycle", 32'(fs0), 32'd0);
      chk("hold_no_strobe", 32'(pos0), 32'd0);

      //            n    ps     pos  vb vs dd  row  line fs fcnt
      tbl[0]  = '{ 16,  6'd8,   16, 0, 1, 0,   2,   0, 0, 1};
      tbl[1]  = '{ 84,  6'd8,  100, 0, 1, 0,  12,   4, 0, 1};
      tbl[2]  = '{379,  6'd16, 479, 0, 1, 1,  59,   7, 0, 1};
      tbl[3]  = '{  1,  6'd16, 480, 1, 1, 0,  59,   7, 0, 1};
      tbl[4]  = '{ 10,  6'd16, 490, 1, 0, 0,  59,   7, 0, 1};
      tbl[5]  = '{ 34,  6'd16, 524, 1, 1, 0,  59,   7, 0, 1};
      tbl[6]  = '{  1,  6'd16,   0, 0, 1, 0,   0,   0, 1, 2};
      tbl[7]  = '{ 16,  6'd16,  16, 0, 1, 0,   1,   0, 0, 2};
      tbl[8]  = '{463,  6'd16, 479, 0, 1, 1,  29,  15, 0, 2};
      tbl[9]  = '{ 46,  6'd0,    0, 0, 1, 0,   0,   0, 1, 3};
      tbl[10] = '{300,  6'd0,  300, 0, 1, 0, 300,   0, 0, 3};
      tbl[11] = '{179,  6'd0,  479, 0, 1, 1, 479,   0, 0, 3};
      tbl[12] = '{ 46,  6'd1,    0, 0, 1, 0,   0,   0, 1, 4};

      for (int v = 0; v < 13; v++) begin
         ps0 = tbl[v].ps;
         run0(tbl[v].n);
         chk($sformatf("tbl%0d_vpos", v),   32'(pos0),  32'(tbl[v].pos));
         chk($sformatf("tbl%0d_vblank", v), 32'(vb0),   32'(tbl[v].vb));
         chk($sformatf("tbl%0d_vsync", v),  32'(vs0),   32'(tbl[v].vs));
         chk($sformatf("tbl%0d_ddone", v),  32'(dd0),   32'(tbl[v].dd));
         chk($sformatf("tbl%0d_row", v),    32'(row0),  32'(tbl[v].row));
         chk($sformatf("tbl%0d_line", v),   32'(line0), 32'(tbl[v].line));
         chk($sformatf("tbl%0d_fs", v),     32'(fs0),   32'(tbl[v].fs));
         chk($sformatf("tbl%0d_fcnt", v),   32'(fc0),   32'(tbl[v].fcnt));
      end

      // 256 back-to-back frames on the 7-line instance
      pulses = 0;
      @(negedge Clk);
      le2 = 1'b1;
      for (int k = 1; k <= 256 * 7; k++) begin
         @(negedge Clk);
         chk($sformatf("b2b_vpos@%0d", k), 32'(pos2), 32'(k % 7));
         chk($sformatf("b2b_fs@%0d", k),   32'(fs2),  32'((k % 7) == 0));
         if (fs2 === 1'b1) pulses++;
         if (k == 255 * 7) chk("b2b_fcnt_255", 32'(fc2), 32'd255);
      end
      le2 = 1'b0;
      chk("b2b_fcnt_wrap", 32'(fc2), 32'd0);
      chk("b2b_pulses", 32'(pulses), 32'd256);

      // Overridden geometry, one 628-line frame
      @(negedge Clk);
      le1 = 1'b1;
      for (int k = 1; k <= 628; k++) begin
         @(negedge Clk);
         exp_pos = k % 628;
         chk($sformatf("ovr_vpos@%0d", k),   32'(pos1), 32'(exp_pos));
         chk($sformatf("ovr_vsync@%0d", k),  32'(vs1),  32'(exp_pos >= 601 && exp_pos <= 604));
         chk($sformatf("ovr_vblank@%0d", k), 32'(vb1),  32'(exp_pos >= 600));
         chk($sformatf("ovr_ddone@%0d", k),  32'(dd1),  32'(exp_pos == 599));
      end
      le1 = 1'b0;
      chk("ovr_fcnt", 32'(fc1), 32'd1);
      chk("ovr_fs", 32'(fs1), 32'd1);

      // Asynchronous reset mid-frame at vPos=300, frame 7
      run0(3 * 525 + 300);
      chk("pre_rst_vpos", 32'(pos0), 32'd300);
      chk("pre_rst_fcnt", 32'(fc0), 32'd7);
      chk("pre_rst_row", 32'(row0), 32'd300);
      @(posedge Clk);
      #2 Rst = 1'b0;
      #1;
      chk_reset0("arst");
      @(negedge Clk);
      Rst = 1'b1;
      pulse0();
      chk("restart_vpos", 32'(pos0), 32'd1);
      chk("restart_fs", 32'(fs0), 32'd0);
      chk("restart_fcnt", 32'(fc0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vsync_gen.md
# vsync_gen

Parametrised vertical timing generator for the VGA display path. It advances one line per end-of-line strobe from the horizontal timing block. It produces vertical blank, sync, position and draw-done signals for any mode geometry. It also generates a pixel-size-scaled cell row/line index and frame-level strobes for the maze renderer.

## Interface
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, front-porch lines
- V_SYNC, 2, sync-pulse lines
- V_BP, 33, back-porch lines
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
- CNT_W, 10, width of vPos; must satisfy 2^CNT_W >= V_TOTAL (V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP)
- Clk  input  1  pixel clock
- Rst  input  1  reset; one clock, asynchronous, active-low
- i_LineEnd  input  1  end-of-line strobe from horizontal timing; each high Clk cycle advances one line
- i_PixelSize  input  6  cell height in lines; 0 treated as 1
- vblank  output  1  high when vPos >= V_ACTIVE
- vsync_out  output  1  sync at SYNC_POL level when V_ACTIVE+V_FP <= vPos < V_ACTIVE+V_FP+V_SYNC, else inverted level
- vPos  output  CNT_W  current line, 0..V_TOTAL-1
- vDrawDone  output  1  high while vPos == V_ACTIVE-1
- o_CellRow  output  10  maze cell row of current line
- o_CellLine  output  6  line offset within current cell
- o_FrameStart  output  1  one-cycle pulse on wrap to line 0
- o_FrameCnt  output  8  frame counter, wraps 255->0

## Operation
- Line counter vCnt (registered) increments on each Clk with i_LineEnd=1.
- It wraps from V_TOTAL-1 to 0; the frame is exactly V_TOTAL lines (default 525, lines 0..524).
- No change when i_LineEnd=0.
- vblank, vsync_out, vPos and vDrawDone decode combinationally from vCnt only.
- Size latch sz (6 bit) loads max(i_PixelSize,1) on the wrap event. Mid-frame changes of i_PixelSize take effect from the next frame's line 0.
- Cell tracking on a line advance into line n (n >= 1):
  - when n < V_ACTIVE: if o_CellLine == sz-1 then o_CellLine=0 and o_CellRow+1, else o_CellLine+1;
  - when n >= V_ACTIVE: both cell outputs hold.
- On wrap, o_CellRow=0 and o_CellLine=0.
- o_CellRow is 10 bit and wraps modulo 1024 with no saturation.
- On a wrap event, o_FrameStart=1 for the following cycle only, and o_FrameCnt increments in the same edge as vCnt returns to 0.
- All counters update on the same edge; there are no intermediate states.

## Timing
- Reset (asynchronous, immediate on Rst=0) values:
  - vCnt=0, hence vPos=0, vblank=0, vDrawDone=0 (1 only if V_ACTIVE==1), vsync_out=~SYNC_POL;
  - o_CellRow=0, o_CellLine=0, o_FrameStart=0, o_FrameCnt=0;
  - sz=1, so the first frame after reset uses cell height 1.
- Latency: every output reflects an i_LineEnd strobe on the Clk edge that samples it, giving one-cycle latency from strobe to new value.
- Consecutive high cycles of i_LineEnd advance one line per cycle; no edge detection.
- o_FrameStart is registered: it is high exactly in the cycle after the wrapping edge. If i_LineEnd is high in that cycle, vPos advances to 1 while the pulse is still high.
- Reset asserted mid-frame aborts the frame. After Rst rises, counting resumes from line 0 on the next strobe, with no o_FrameStart for that restart.

## Test plan
- Reset with Rst=0 at vPos=300 and o_FrameCnt=7 -> all outputs immediately at reset values (vsync_out=1 for defaults), without waiting for a Clk edge.
- Defaults, 525 single-cycle strobes:
  - vblank rises after strobe 480;
  - vDrawDone high only at vPos=479;
  - vsync_out=0 only at vPos 490,491;
  - strobe 525 gives vPos=0, o_FrameStart high one cycle, o_FrameCnt=1.
- i_PixelSize=8 from reset, one frame run to prime sz, then 16 strobes -> o_CellRow=2, o_CellLine=0. At vPos=479: o_CellRow=59, o_CellLine=7; both held through blanking; both 0 after wrap.
- Size 8 latched, then i_PixelSize=16 at vPos=100 -> stepping stays at 8 for the rest of the frame; the next frame reaches o_CellRow=1 at vPos=16. i_PixelSize=0 -> behaves as 1 (o_CellRow == vPos in the active region).
- 256 frames of back-to-back strobes (i_LineEnd held high) -> o_FrameCnt wraps 255->0; one line per cycle throughout; exactly 256 o_FrameStart pulses.
- Override V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23, SYNC_POL=1 -> frame is 628 lines; vsync_out=1 only at vPos 601..604; vblank from 600; wrap after vPos=627.
